// File: rtl/fifo_sync_use.sv
// Single-clock FIFO with full/empty flags, a registered read-valid strobe and
// registered occupancy counts, port-compatible with the dual-clock variant.
module fifo_sync_use #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] wdata,
    input  logic             w_en,
    output logic             w_full,
    output logic [ASIZE-1:0] wuse,
    output logic [DSIZE-1:0] rdata,
    output logic             r_empty,
    input  logic             r_en,
    output logic             r_ok,
    output logic [ASIZE-1:0] ruse
);

    localparam int DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] mem_q [DEPTH];

    logic [ASIZE:0]   wptr_q, wptr_d;
    logic [ASIZE:0]   rptr_q, rptr_d;
    logic [ASIZE-1:0] use_q, use_d;
    logic [DSIZE-1:0] rdata_q, rdata_d;
    logic             r_ok_q, r_ok_d;
    logic             wr_acc, rd_acc;

    // Flags come straight from the pre-edge pointers; the MSB tells full from empty.
    assign r_empty = (wptr_q == rptr_q);
    assign w_full  = (wptr_q[ASIZE] != rptr_q[ASIZE]) &&
                     (wptr_q[ASIZE-1:0] == rptr_q[ASIZE-1:0]);

    always_comb begin
        wr_acc  = w_en && !w_full;
        rd_acc  = r_en && !r_empty;
        wptr_d  = wptr_q + {{ASIZE{1'b0}}, wr_acc};
        rptr_d  = rptr_q + {{ASIZE{1'b0}}, rd_acc};
        rdata_d = rdata_q;
        if (rd_acc) begin
            rdata_d = mem_q[rptr_q[ASIZE-1:0]];
        end
        r_ok_d  = rd_acc;
        // Occupancy after this edge; a full FIFO wraps to 0 and relies on w_full.
        use_d   = wptr_d[ASIZE-1:0] - rptr_d[ASIZE-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            use_q   <= '0;
            rdata_q <= '0;
            r_ok_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            use_q   <= use_d;
            rdata_q <= rdata_d;
            r_ok_q  <= r_ok_d;
        end
    end

    // Storage is never cleared; reset only empties it by resetting the pointers.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wptr_q[ASIZE-1:0]] <= wdata;
        end
    end

    assign wuse  = use_q;
    assign ruse  = use_q;
    assign rdata = rdata_q;
    assign r_ok  = r_ok_q;

endmodule

// File: tb/tb_fifo_sync_use.sv
// Scoreboard bench for fifo_sync_use: directed fill/drain/concurrent/boundary/reset
// sequences, with read data checked by a separate monitor against queued expectations.
module tb_fifo_sync_use;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wdata;
    logic       w_en;
    logic       w_full;
    logic [4:0] wuse;
    logic [7:0] rdata;
    logic       r_empty;
    logic       r_en;
    logic       r_ok;
    logic [4:0] ruse;

    int checks = 0;
    int errors = 0;

    logic [7:0] model[$];
    logic [7:0] exp_q[$];

    fifo_sync_use #(.DSIZE(8), .ASIZE(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .wdata   (wdata),
        .w_en    (w_en),
        .w_full  (w_full),
        .wuse    (wuse),
        .rdata   (rdata),
        .r_empty (r_empty),
        .r_en    (r_en),
        .r_ok    (r_ok),
        .ruse    (ruse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one cycle of stimulus, update the reference queue, then check flags/counts.
    task automatic step(input logic we, input logic [7:0] wd, input logic re);
        bit wacc, racc;
        int n;
        w_en  = we;
        wdata = wd;
        r_en  = re;
        wacc  = we && (model.size() < 32);
        racc  = re && (model.size() != 0);
        if (racc) exp_q.push_back(model.pop_front());
        if (wacc) model.push_back(wd);
        @(posedge clk);
        #1;
        n = model.size();
        check("r_ok", {31'd0, r_ok}, {31'd0, racc});
        check("wuse", {27'd0, wuse}, n % 32);
        check("ruse", {27'd0, ruse}, n % 32);
        check("w_full", {31'd0, w_full}, {31'd0, (n == 32)});
        check("r_empty", {31'd0, r_empty}, {31'd0, (n == 0)});
    endtask

    // Monitor: every presented read result must match the oldest expected word.
    always @(negedge clk) begin
        if (rst === 1'b0 && r_ok === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rdata_unexpected: got %0h with no read pending at %0t", rdata, $time);
            end else begin
                check("rdata", {24'd0, rdata}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        w_en  = 1'b1;
        r_en  = 1'b1;
        wdata = 8'h77;
        repeat (2) @(posedge clk);
        #1;
        check("rst_r_empty", {31'd0, r_empty}, 32'd1);
        check("rst_w_full", {31'd0, w_full}, 32'd0);
        check("rst_wuse", {27'd0, wuse}, 32'd0);
        check("rst_ruse", {27'd0, ruse}, 32'd0);
        check("rst_r_ok", {31'd0, r_ok}, 32'd0);
        check("rst_rdata", {24'd0, rdata}, 32'd0);
        rst  = 1'b0;
        w_en = 1'b0;
        r_en = 1'b0;

        // Fill 0..31, then a dropped 33rd write.
        for (int i = 0; i < 32; i++) step(1'b1, 8'(i), 1'b0);
        check("fill_w_full", {31'd0, w_full}, 32'd1);
        check("fill_wuse", {27'd0, wuse}, 32'd0);
        step(1'b1, 8'd32, 1'b0);
        check("drop_wuse", {27'd0, wuse}, 32'd0);

        // Drain: 32 reads yield 0..31, then an ignored read holds 31.
        for (int i = 0; i < 32; i++) step(1'b0, 8'd0, 1'b1);
        step(1'b0, 8'd0, 1'b1);
        check("drain_r_ok", {31'd0, r_ok}, 32'd0);
        check("drain_hold", {24'd0, rdata}, 32'd31);

        // Empty with both enables: only the write happens.
        step(1'b1, 8'h3C, 1'b1);
        check("empty_both_wuse", {27'd0, wuse}, 32'd1);
        check("empty_both_r_ok", {31'd0, r_ok}, 32'd0);
        step(1'b0, 8'd0, 1'b1);

        // Concurrent streaming with 5 queued words.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h80 + i), 1'b1);
        check("conc_wuse", {27'd0, wuse}, 32'd5);
        for (int i = 0; i < 5; i++) step(1'b0, 8'd0, 1'b1);

        // Full with both enables: only the read happens.
        for (int i = 0; i < 32; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
        step(1'b1, 8'hEE, 1'b1);
        check("full_both_w_full", {31'd0, w_full}, 32'd0);
        check("full_both_wuse", {27'd0, wuse}, 32'd31);
        for (int i = 0; i < 31; i++) step(1'b0, 8'd0, 1'b1);
        step(1'b0, 8'd0, 1'b0);

        // Mid-run reset with 10 words held.
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_r_empty", {31'd0, r_empty}, 32'd1);
        check("midrst_wuse", {27'd0, wuse}, 32'd0);
        model.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 8'hA5, 1'b0);
        step(1'b0, 8'd0, 1'b1);
        check("midrst_rdata", {24'd0, rdata}, 32'hA5);
        step(1'b0, 8'd0, 1'b0);

        @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
